rx_ts_detect16: RTL and testbench

Receive-side training-sequence detector for the 16-bit PIPE interface of the TI PHY design. It sits directly downstream of the PHY receive pins `rxdata16`, `rxdatak16`, `rxvalid16` and `rxidle16`, and feeds the LTSSM. It aligns COM symbols arriving in either byte lane and checks TS1/TS2 ordered sets symbol by symbol. For each good set it reports the decoded fields and a count of consecutive identical sets; malformed sets raise an error pulse.

---
 rtl/rx_ts_detect16_if.sv | 31 +++
 rtl/rx_ts_detect16.sv | 213 +++++++++++++++++++++
 tb/tb_rx_ts_detect16.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_ts_detect16_if.sv
// PIPE 16-bit receive symbols toward the TS detector and the decoded TS report back to the LTSSM.
// master drives the PHY receive side; slave is the detector.
interface rx_ts_detect16_if;
    logic [15:0] rxdata16;
    logic [1:0]  rxdatak16;
    logic        rxvalid16;
    logic        rxidle16;
    logic        ts1_valid;
    logic        ts2_valid;
    logic        ts_err;
    logic [7:0]  ts_link;
    logic [7:0]  ts_lane;
    logic [7:0]  ts_nfts;
    logic [7:0]  ts_rate;
    logic [7:0]  ts_ctrl;
    logic        ts_link_pad;
    logic        ts_lane_pad;
    logic [3:0]  ts_consec;

    modport master (
        output rxdata16, rxdatak16, rxvalid16, rxidle16,
        input  ts1_valid, ts2_valid, ts_err, ts_link, ts_lane, ts_nfts, ts_rate, ts_ctrl,
               ts_link_pad, ts_lane_pad, ts_consec
    );

    modport slave (
        input  rxdata16, rxdatak16, rxvalid16, rxidle16,
        output ts1_valid, ts2_valid, ts_err, ts_link, ts_lane, ts_nfts, ts_rate, ts_ctrl,
               ts_link_pad, ts_lane_pad, ts_consec
    );
endinterface

// File: rtl/rx_ts_detect16.sv
// TS1/TS2 detector on the 16-bit PIPE receive path: COM alignment in either lane, per-symbol checks, field report.
// Registered outputs, pulse one cycle after symbol 15; no backpressure, one symbol pair consumed per valid cycle.
module rx_ts_detect16 #(
    parameter int CONSEC_MAX = 15
) (
    input  logic            rxclk,
    input  logic            rst,
    rx_ts_detect16_if.slave rx
);
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] SYM_TS1 = 8'h4A;
    localparam logic [7:0] SYM_TS2 = 8'h45;

    typedef enum logic [1:0] {HUNT, HDR, ID} state_t;

    state_t     state, state_nxt;
    logic [3:0] idx, idx_nxt;
    logic       phase, phase_nxt;

    logic [7:0] hold_dat;
    logic       hold_k;
    logic [7:0] sa, sb;
    logic       ka, kb;
    logic       com0, com1, skp_h, skp_b, ok_a, ok_b, ok_h;
    logic       err_set, good_set, link_start, idle_clr;

    logic [7:0] sh_link, sh_lane, sh_nfts, sh_rate, sh_ctrl, sh_id;
    logic       sh_link_pad, sh_lane_pad, last_ts2, key_eq;

    function automatic logic sym_ok(input logic [3:0] i, input logic [7:0] d, input logic k,
                                    input logic [7:0] id_ref);
        logic ok;
        case (i)
            4'd0:             ok = 1'b1;
            4'd1, 4'd2:       ok = !k || (d == SYM_PAD);
            4'd3, 4'd4, 4'd5: ok = !k;
            4'd6:             ok = !k && ((d == SYM_TS1) || (d == SYM_TS2));
            default:          ok = !k && (d == id_ref);
        endcase
        return ok;
    endfunction

    // Even symbols are always the earlier half of a pair, so symbol 7 checks against symbol 6 in the same cycle.
    always_comb begin
        com0  = rx.rxdatak16[0] && (rx.rxdata16[7:0] == SYM_COM);
        com1  = rx.rxdatak16[1] && (rx.rxdata16[15:8] == SYM_COM);
        skp_h = rx.rxdatak16[1] && (rx.rxdata16[15:8] == SYM_SKP);
        if (phase) begin
            sa = hold_dat;
            ka = hold_k;
            sb = rx.rxdata16[7:0];
            kb = rx.rxdatak16[0];
        end else begin
            sa = rx.rxdata16[7:0];
            ka = rx.rxdatak16[0];
            sb = rx.rxdata16[15:8];
            kb = rx.rxdatak16[1];
        end
        skp_b  = (idx == 4'd0) && kb && (sb == SYM_SKP);
        ok_a   = sym_ok(idx, sa, ka, sh_id);
        ok_b   = sym_ok(idx | 4'd1, sb, kb, (idx == 4'd6) ? sa : sh_id);
        ok_h   = sym_ok(4'd1, rx.rxdata16[15:8], rx.rxdatak16[1], sh_id);
        key_eq = {sh_id == SYM_TS2, sh_link, sh_lane, sh_nfts, sh_rate, sh_ctrl, sh_link_pad, sh_lane_pad}
              == {last_ts2, rx.ts_link, rx.ts_lane, rx.ts_nfts, rx.ts_rate, rx.ts_ctrl,
                  rx.ts_link_pad, rx.ts_lane_pad};
    end

    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            idx   <= 4'd0;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        phase_nxt  = phase;
        err_set    = 1'b0;
        good_set   = 1'b0;
        link_start = 1'b0;
        idle_clr   = 1'b0;
        if (rx.rxidle16) begin
            state_nxt = HUNT;
            idle_clr  = 1'b1;
        end else begin
            case (state)
                HUNT: begin
                    if (rx.rxvalid16) begin
                        if (com1) begin
                            state_nxt = HDR;
                            idx_nxt   = 4'd0;
                            phase_nxt = 1'b1;
                        end else if (com0) begin
                            phase_nxt = 1'b0;
                            if (!skp_h) begin
                                if (ok_h) begin
                                    state_nxt  = HDR;
                                    idx_nxt    = 4'd2;
                                    link_start = 1'b1;
                                end else begin
                                    err_set = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    if (!rx.rxvalid16 || (!skp_b && !(ok_a && ok_b))) begin
                        err_set   = 1'b1;
                        state_nxt = HUNT;
                    end else if (skp_b) begin
                        state_nxt = HUNT;
                    end else if (idx == 4'd14) begin
                        good_set  = 1'b1;
                        state_nxt = HUNT;
                        // Phase 1 delivers symbol 15 on byte0, so byte1 may already carry the next COM.
                        if (phase && com1) begin
                            state_nxt = HDR;
                            idx_nxt   = 4'd0;
                        end
                    end else begin
                        idx_nxt   = idx + 4'd2;
                        state_nxt = (idx >= 4'd4) ? ID : HDR;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            hold_dat       <= 8'h00;
            hold_k         <= 1'b0;
            sh_link        <= 8'h00;
            sh_lane        <= 8'h00;
            sh_nfts        <= 8'h00;
            sh_rate        <= 8'h00;
            sh_ctrl        <= 8'h00;
            sh_id          <= 8'h00;
            sh_link_pad    <= 1'b0;
            sh_lane_pad    <= 1'b0;
            last_ts2       <= 1'b0;
            rx.ts1_valid   <= 1'b0;
            rx.ts2_valid   <= 1'b0;
            rx.ts_err      <= 1'b0;
            rx.ts_link     <= 8'h00;
            rx.ts_lane     <= 8'h00;
            rx.ts_nfts     <= 8'h00;
            rx.ts_rate     <= 8'h00;
            rx.ts_ctrl     <= 8'h00;
            rx.ts_link_pad <= 1'b0;
            rx.ts_lane_pad <= 1'b0;
            rx.ts_consec   <= 4'd0;
        end else begin
            rx.ts1_valid <= 1'b0;
            rx.ts2_valid <= 1'b0;
            rx.ts_err    <= err_set;
            if (rx.rxvalid16) begin
                hold_dat <= rx.rxdata16[15:8];
                hold_k   <= rx.rxdatak16[1];
            end
            if (link_start) begin
                sh_link     <= rx.rxdata16[15:8];
                sh_link_pad <= skp_h ? 1'b0 : (rx.rxdatak16[1] && (rx.rxdata16[15:8] == SYM_PAD));
            end
            if ((state != HUNT) && rx.rxvalid16) begin
                case (idx)
                    4'd0: begin
                        sh_link     <= sb;
                        sh_link_pad <= kb && (sb == SYM_PAD);
                    end
                    4'd2: begin
                        sh_lane     <= sa;
                        sh_lane_pad <= ka && (sa == SYM_PAD);
                        sh_nfts     <= sb;
                    end
                    4'd4: begin
                        sh_rate <= sa;
                        sh_ctrl <= sb;
                    end
                    4'd6:    sh_id <= sa;
                    default: begin end
                endcase
            end
            if (idle_clr || err_set) begin
                rx.ts_consec <= 4'd0;
            end else if (good_set) begin
                rx.ts_link     <= sh_link;
                rx.ts_lane     <= sh_lane;
                rx.ts_nfts     <= sh_nfts;
                rx.ts_rate     <= sh_rate;
                rx.ts_ctrl     <= sh_ctrl;
                rx.ts_link_pad <= sh_link_pad;
                rx.ts_lane_pad <= sh_lane_pad;
                last_ts2       <= (sh_id == SYM_TS2);
                rx.ts1_valid   <= (sh_id == SYM_TS1);
                rx.ts2_valid   <= (sh_id == SYM_TS2);
                if (!key_eq)
                    rx.ts_consec <= 4'd1;
                else if (rx.ts_consec != 4'(CONSEC_MAX))
                    rx.ts_consec <= rx.ts_consec + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_rx_ts_detect16.sv
// Bench for rx_ts_detect16: byte-stream stimulus tagged with expected reports, checked by an independent monitor.
module tb_rx_ts_detect16;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] PAD = 8'hF7;
    localparam logic [7:0] TS1 = 8'h4A;
    localparam logic [7:0] TS2 = 8'h45;
    localparam int K_TS1 = 0;
    localparam int K_TS2 = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] link, lane, nfts, rate, ctrl;
        logic       lp, np;
        logic [3:0] consec;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       k;
        bit         tag;
        exp_t       e;
    } sym_t;

    logic rxclk = 1'b0;
    logic rst   = 1'b1;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    sym_t stream[$];

    rx_ts_detect16_if bus();

    rx_ts_detect16 #(.CONSEC_MAX(15)) dut (
        .rxclk (rxclk),
        .rst   (rst),
        .rx    (bus.slave)
    );

    always #5 rxclk = ~rxclk;
    always @(posedge rxclk) cyc <= cyc + 1;

    function automatic logic [63:0] all_outs();
        return 64'({bus.ts1_valid, bus.ts2_valid, bus.ts_err, bus.ts_link, bus.ts_lane, bus.ts_nfts,
                    bus.ts_rate, bus.ts_ctrl, bus.ts_link_pad, bus.ts_lane_pad, bus.ts_consec});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge rxclk) begin
        if (!rst && (bus.ts1_valid || bus.ts2_valid || bus.ts_err)) begin
            int   act_kind;
            exp_t e;
            if (32'(bus.ts1_valid) + 32'(bus.ts2_valid) + 32'(bus.ts_err) > 1) act_kind = 3;
            else if (bus.ts_err)    act_kind = K_ERR;
            else if (bus.ts2_valid) act_kind = K_TS2;
            else                    act_kind = K_TS1;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected no pulse", act_kind, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 64'(act_kind), 64'(e.kind));
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                check("consec", 64'(bus.ts_consec), 64'(e.consec));
                if (e.kind != K_ERR)
                    check("fields", 64'({bus.ts_link, bus.ts_lane, bus.ts_nfts, bus.ts_rate, bus.ts_ctrl,
                                         bus.ts_link_pad, bus.ts_lane_pad}),
                                    64'({e.link, e.lane, e.nfts, e.rate, e.ctrl, e.lp, e.np}));
            end
        end
    end

    task automatic issue(input logic [15:0] d, input logic [1:0] k, input logic v, input logic idle);
        bus.rxdata16  = d;
        bus.rxdatak16 = k;
        bus.rxvalid16 = v;
        bus.rxidle16  = idle;
        @(posedge rxclk);
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) issue(16'h0000, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic add_sym(input logic [7:0] d, input logic k);
        sym_t s;
        s.d   = d;
        s.k   = k;
        s.tag = 1'b0;
        stream.push_back(s);
    endtask

    // pos < 0: no report expected; pos == 0: good set; pos > 0: symbol pos replaced by bad and an error expected.
    task automatic add_set(input logic [7:0] link, input logic lk, input logic [7:0] lane, input logic nk,
                           input logic [7:0] nfts, input logic [7:0] rate, input logic [7:0] ctrl,
                           input logic [7:0] id, input int pos, input logic [7:0] bad, input int consec);
        sym_t s[16];
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            s[i].d   = id;
            s[i].k   = 1'b0;
            s[i].tag = 1'b0;
        end
        s[0].d = COM;  s[0].k = 1'b1;
        s[1].d = link; s[1].k = lk;
        s[2].d = lane; s[2].k = nk;
        s[3].d = nfts;
        s[4].d = rate;
        s[5].d = ctrl;
        e.cyc = 0;
        e.link = link; e.lane = lane; e.nfts = nfts; e.rate = rate; e.ctrl = ctrl;
        e.lp = lk && (link == PAD);
        e.np = nk && (lane == PAD);
        e.consec = 4'(consec);
        e.kind = (id == TS2) ? K_TS2 : K_TS1;
        if (pos > 0) begin
            s[pos].d   = bad;
            e.kind     = K_ERR;
            e.consec   = 4'd0;
            s[pos].tag = 1'b1;
            s[pos].e   = e;
        end else if (pos == 0) begin
            s[15].tag = 1'b1;
            s[15].e   = e;
        end
        for (int i = 0; i < 16; i++) stream.push_back(s[i]);
    endtask

    task automatic push_err();
        exp_t e;
        e.kind = K_ERR;
        e.cyc = cyc;
        e.consec = 4'd0;
        sb.push_back(e);
    endtask

    task automatic flush(input int ncyc);
        sym_t a, b;
        int   n;
        n = 0;
        while (stream.size() > 0 && (ncyc < 0 || n < ncyc)) begin
            a = stream.pop_front();
            if (stream.size() > 0) b = stream.pop_front();
            else begin b.d = 8'h00; b.k = 1'b0; b.tag = 1'b0; end
            issue({b.d, a.d}, {b.k, a.k}, 1'b1, 1'b0);
            if (a.tag) begin a.e.cyc = cyc; sb.push_back(a.e); end
            if (b.tag) begin b.e.cyc = cyc; sb.push_back(b.e); end
            n++;
        end
    endtask

    initial begin
        bus.rxdata16  = 16'h0000;
        bus.rxdatak16 = 2'b00;
        bus.rxvalid16 = 1'b0;
        bus.rxidle16  = 1'b0;
        repeat (3) @(posedge rxclk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        gap(2);
        check("idle_after_reset", all_outs(), 64'd0);

        // Phase 0 TS1
        add_set(8'h01, 0, 8'h00, 0, 8'h20, 8'h02, 8'h00, TS1, 0, 8'h00, 1);
        flush(-1);
        gap(2);

        // Phase 1 TS2 with PAD link/lane, 8 gapless copies
        add_sym(8'h00, 0);
        for (int i = 0; i < 8; i++) add_set(PAD, 1, PAD, 1, 8'h10, 8'h02, 8'h00, TS2, 0, 8'h00, i + 1);
        add_sym(8'h00, 0);
        flush(-1);
        gap(2);

        // Saturation at 15, then a key change
        for (int i = 1; i <= 20; i++)
            add_set(8'h01, 0, 8'h00, 0, 8'h20, 8'h02, 8'h00, TS1, 0, 8'h00, (i < 15) ? i : 15);
        add_set(8'h01, 0, 8'h00, 0, 8'h21, 8'h02, 8'h00, TS1, 0, 8'h00, 1);
        flush(-1);
        gap(2);

        // Corrupt identifier on symbol 9
        add_set(8'h01, 0, 8'h00, 0, 8'h20, 8'h02, 8'h00, TS1, 9, 8'h4B, 0);
        flush(-1);
        gap(2);
        check("consec_after_err", 64'(bus.ts_consec), 64'd0);
        check("fields_held_after_err", 64'(bus.ts_nfts), 64'h21);
        add_set(8'h01, 0, 8'h00, 0, 8'h20, 8'h02, 8'h00, TS1, 0, 8'h00, 1);
        flush(-1);
        gap(2);

        // SKP ordered sets in both phases
        add_sym(COM, 1); add_sym(SKP, 1); add_sym(SKP, 1); add_sym(SKP, 1);
        add_sym(8'h00, 0); add_sym(COM, 1); add_sym(SKP, 1); add_sym(SKP, 1); add_sym(SKP, 1);
        add_sym(8'h00, 0);
        flush(-1);
        gap(2);
        check("consec_after_skp", 64'(bus.ts_consec), 64'd1);

        // rxvalid16 drop at symbol 6
        add_set(8'h01, 0, 8'h00, 0, 8'h20, 8'h02, 8'h00, TS1, -1, 8'h00, 0);
        flush(3);
        issue(16'h4A4A, 2'b00, 1'b0, 1'b0);
        push_err();
        flush(-1);
        gap(2);
        check("consec_after_stall", 64'(bus.ts_consec), 64'd0);

        // Electrical idle mid-set
        add_set(8'h01, 0, 8'h00, 0, 8'h20, 8'h02, 8'h00, TS1, 0, 8'h00, 1);
        flush(-1);
        gap(1);
        add_set(8'h01, 0, 8'h00, 0, 8'h20, 8'h02, 8'h00, TS1, -1, 8'h00, 0);
        flush(4);
        issue(16'h4A4A, 2'b00, 1'b0, 1'b1);
        flush(-1);
        gap(2);
        check("consec_after_idle", 64'(bus.ts_consec), 64'd0);

        // Asynchronous reset at symbol 8
        add_set(8'h01, 0, 8'h00, 0, 8'h20, 8'h02, 8'h00, TS1, 0, 8'h00, 1);
        flush(-1);
        gap(1);
        add_set(8'h01, 0, 8'h00, 0, 8'h20, 8'h02, 8'h00, TS1, -1, 8'h00, 0);
        flush(4);
        bus.rxdata16  = 16'h4A4A;
        bus.rxdatak16 = 2'b00;
        bus.rxvalid16 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("outputs_in_midset_reset", all_outs(), 64'd0);
        @(posedge rxclk);
        #1;
        rst = 1'b0;
        stream.delete();
        gap(2);
        add_set(8'h01, 0, 8'h00, 0, 8'h20, 8'h02, 8'h00, TS1, 0, 8'h00, 1);
        flush(-1);
        gap(3);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
